// File: rtl/alu_pkg.sv
// Shared ALU encodings for the execute stage: control codes,
// alu_op and funct values, and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ORI   = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/alu_ctr_decode.sv
// Combinational ALU control decode: {alu_op, funct} to a 4-bit
// control code plus an illegal-funct flag.
module alu_ctr_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       illegal
);

  always_comb begin
    alu_ctr = ALU_ILL;
    illegal = 1'b0;
    unique case (1'b1)
      alu_op == OP_ADD: alu_ctr = ALU_ADD;
      alu_op == OP_BEQ: alu_ctr = ALU_SUB;
      alu_op == OP_ORI: alu_ctr = ALU_OR;
      alu_op == OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_ctr = ALU_ADD;
          F_SUB:   alu_ctr = ALU_SUB;
          F_AND:   alu_ctr = ALU_AND;
          F_OR:    alu_ctr = ALU_OR;
          F_SLT:   alu_ctr = ALU_SLT;
          F_NOR:   alu_ctr = ALU_NOR;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU front end: ID/EX operand regs, EX/MEM result reg.
// Optional ALU_EXEC_CTRL_ILLEGAL_TRAP_EN adds the illegal_op output.
module alu_exec_ctrl #(
  parameter int DW   = 32,
  parameter int IMMW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic            alu_src,
  input  logic [DW-1:0]   rs_data,
  input  logic [DW-1:0]   rt_data,
  input  logic [IMMW-1:0] imm,
  output logic [DW-1:0]   di1,
  output logic [DW-1:0]   di2,
  output logic [3:0]      alu_ctr,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   result,
  output logic            res_zero,
  output logic            branch_taken
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic            illegal_op
`endif
);

  import alu_pkg::*;

  logic [1:0]    state;
  logic          accept;
  logic [3:0]    dec_ctr;
  logic          dec_ill;
  logic [DW-1:0] ext_imm;
  logic [DW-1:0] op2;
  logic          is_beq;
  logic [DW-1:0] res_d;
  logic          br_d;

  alu_ctr_decode u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_ctr (dec_ctr),
    .illegal (dec_ill)
  );

  // ori takes a logical immediate; everything else is signed
  assign ext_imm = (alu_op == OP_ORI)
                 ? {{(DW-IMMW){1'b0}}, imm}
                 : {{(DW-IMMW){imm[IMMW-1]}}, imm};

  assign op2       = alu_src ? ext_imm : rt_data;
  assign in_ready  = (state == S_IDLE) ||
                     (state == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
  logic ill_q;

  assign res_d = ill_q ? '0 : alu_out;
  assign br_d  = is_beq & alu_zero & ~ill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q      <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept) begin
      ill_q <= dec_ill;
    end else if (state == S_EXEC) begin
      illegal_op <= ill_q;
    end
  end
`else
  assign res_d = alu_out;
  assign br_d  = is_beq & alu_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      di1          <= '0;
      di2          <= '0;
      alu_ctr      <= ALU_ILL;
      is_beq       <= 1'b0;
      result       <= '0;
      res_zero     <= 1'b0;
      branch_taken <= 1'b0;
    end else if (accept) begin
      di1     <= rs_data;
      di2     <= op2;
      alu_ctr <= dec_ctr;
      is_beq  <= (alu_op == OP_BEQ) & ~dec_ill;
      state   <= S_EXEC;
    end else if (state == S_EXEC) begin
      result       <= res_d;
      res_zero     <= alu_zero;
      branch_taken <= br_d;
      state        <= S_DONE;
    end else if (state != S_IDLE &&
                 (state != S_DONE || out_ready)) begin
      // also recovers the unused encoding
      state <= S_IDLE;
    end
  end

endmodule
